alu_issue: RTL and testbench

Decode/issue stage that sits directly upstream of the integer ALU. It is the producer side of the ALU's operand/function interface. It accepts one RV32I instruction per handshake, reads the register-file operands, and decodes the instruction into `input_a`, `input_b`, `function_select` and `function_modifier`. It then presents these as a registered, valid/ready pipeline stage to the execute stage.

---
 rtl/alu_issue_if.sv | 34 +++
 rtl/alu_issue.sv | 172 +++++++++++++++++
 tb/tb_alu_issue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Operand/function bundle between fetch, register file, the issue stage and the ALU.
// The issue stage uses the slave modport; its environment uses master.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic [2:0]  function_select;
  logic        function_modifier;
  logic [4:0]  rd;
  logic        rd_write;
  logic        illegal;

  modport master (
    output in_valid, in_instruction, in_pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, input_a, input_b,
           function_select, function_modifier, rd, rd_write, illegal
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, input_a, input_b,
           function_select, function_modifier, rd, rd_write, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: selects and sign-extends ALU operands and registers
// them behind a single valid/ready pipeline slot.
module alu_issue (
  input  logic      clk,
  input  logic      reset,
  alu_issue_if.slave bus
);
  localparam logic [2:0] ALU_ADD_SUB = 3'd0;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;

  assign instr  = bus.in_instruction;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};

  assign bus.rs1_addr = instr[19:15];
  assign bus.rs2_addr = instr[24:20];

  logic        dec_legal;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [2:0]  dec_sel;
  logic        dec_mod;

  always_comb begin
    dec_legal = 1'b0;
    dec_a     = '0;
    dec_b     = '0;
    dec_sel   = ALU_ADD_SUB;
    dec_mod   = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a   = bus.rs1_data;
        dec_b   = bus.rs2_data;
        dec_sel = f3;
        if (f7 == F7_BASE) begin
          dec_legal = 1'b1;
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec_legal = 1'b1;
          dec_mod   = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_a   = bus.rs1_data;
        dec_b   = imm_i;
        dec_sel = f3;
        case (f3)
          3'b001: dec_legal = (f7 == F7_BASE);
          3'b101: begin
            dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec_mod   = instr[30];
          end
          default: dec_legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_b     = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_a     = bus.in_pc;
        dec_b     = imm_u;
      end
      OPC_JAL: begin
        dec_legal = 1'b1;
        dec_a     = bus.in_pc;
        dec_b     = 32'd4;
      end
      OPC_JALR: begin
        dec_legal = (f3 == 3'b000);
        dec_a     = bus.in_pc;
        dec_b     = 32'd4;
      end
      default: dec_legal = 1'b0;
    endcase
    // Illegal encodings present a fully zeroed operation to the ALU.
    if (!dec_legal) begin
      dec_a   = '0;
      dec_b   = '0;
      dec_sel = ALU_ADD_SUB;
      dec_mod = 1'b0;
    end
  end

  logic        out_valid_q, out_valid_d;
  logic [31:0] input_a_q, input_a_d;
  logic [31:0] input_b_q, input_b_d;
  logic [2:0]  sel_q, sel_d;
  logic        mod_q, mod_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_write_q, rd_write_d;
  logic        illegal_q, illegal_d;
  logic        accept;

  assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    out_valid_d = out_valid_q;
    input_a_d   = input_a_q;
    input_b_d   = input_b_q;
    sel_d       = sel_q;
    mod_d       = mod_q;
    rd_d        = rd_q;
    rd_write_d  = rd_write_q;
    illegal_d   = illegal_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      input_a_d   = dec_a;
      input_b_d   = dec_b;
      sel_d       = dec_sel;
      mod_d       = dec_mod;
      rd_d        = dec_legal ? instr[11:7] : 5'd0;
      rd_write_d  = dec_legal && (instr[11:7] != 5'd0);
      illegal_d   = !dec_legal;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      input_a_q   <= '0;
      input_b_q   <= '0;
      sel_q       <= '0;
      mod_q       <= 1'b0;
      rd_q        <= '0;
      rd_write_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      input_a_q   <= input_a_d;
      input_b_q   <= input_b_d;
      sel_q       <= sel_d;
      mod_q       <= mod_d;
      rd_q        <= rd_d;
      rd_write_q  <= rd_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.out_valid         = out_valid_q;
  assign bus.input_a           = input_a_q;
  assign bus.input_b           = input_b_q;
  assign bus.function_select   = sel_q;
  assign bus.function_modifier = mod_q;
  assign bus.rd                = rd_q;
  assign bus.rd_write          = rd_write_q;
  assign bus.illegal           = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure, flush and reset.
module tb_alu_issue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_if bus();

  alu_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] sel, input logic md,
                           input logic [4:0] rdx, input logic rdw, input logic ill);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".input_a"},   bus.input_a, a);
    check({tag, ".input_b"},   bus.input_b, b);
    check({tag, ".select"},    32'(bus.function_select), 32'(sel));
    check({tag, ".modifier"},  32'(bus.function_modifier), 32'(md));
    check({tag, ".rd"},        32'(bus.rd), 32'(rdx));
    check({tag, ".rd_write"},  32'(bus.rd_write), 32'(rdw));
    check({tag, ".illegal"},   32'(bus.illegal), 32'(ill));
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid       = 1'b1;
    bus.in_instruction = ins;
    bus.in_pc          = pc;
    bus.rs1_data       = r1;
    bus.rs2_data       = r2;
    tick();
    bus.in_valid = 1'b0;
    $display("[TB] issue instr=0x%08h pc=0x%08h rs1=0x%08h rs2=0x%08h", ins, pc, r1, r2);
  endtask

  initial begin
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_instruction = '0;
    bus.in_pc          = '0;
    bus.rs1_data       = '0;
    bus.rs2_data       = '0;
    bus.flush          = 1'b0;
    bus.out_ready      = 1'b0;

    tick();
    tick();
    check_out("reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("release.in_ready", 32'(bus.in_ready), 32'd1);

    // SUB x3,x1,x2 with register-address lookahead check
    bus.out_ready      = 1'b1;
    bus.in_instruction = 32'h402081B3;
    #1;
    check("sub.rs1_addr", 32'(bus.rs1_addr), 32'd1);
    check("sub.rs2_addr", 32'(bus.rs2_addr), 32'd2);
    issue(32'h402081B3, 32'h0, 32'd10, 32'd3);
    check_out("sub", 1'b1, 32'd10, 32'd3, 3'd0, 1'b1, 5'd3, 1'b1, 1'b0);

    issue(32'h40335293, 32'h0, 32'h80000000, 32'h0);
    check_out("srai", 1'b1, 32'h80000000, 32'h00000403, 3'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    issue(32'h42335293, 32'h0, 32'h80000000, 32'h0);
    check_out("srai_bad", 1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    issue(32'h123453B7, 32'h0, 32'h55, 32'h66);
    check_out("lui", 1'b1, 32'h0, 32'h12345000, 3'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    issue(32'hFFF00093, 32'h0, 32'h0, 32'h0);
    check_out("addi", 1'b1, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    issue(32'h00001217, 32'h100, 32'h0, 32'h0);
    check_out("auipc", 1'b1, 32'h100, 32'h1000, 3'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    issue(32'h000000EF, 32'h200, 32'h0, 32'h0);
    check_out("jal", 1'b1, 32'h200, 32'h4, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    issue(32'h000010E7, 32'h300, 32'h0, 32'h0);
    check_out("jalr_bad", 1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    issue(32'h4020E1B3, 32'h0, 32'd1, 32'd2);
    check_out("or_bad", 1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    issue(32'h02009093, 32'h0, 32'd1, 32'd2);
    check_out("slli_bad", 1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    issue(32'h0020C333, 32'h0, 32'h0000F0F0, 32'h00000FF0);
    check_out("xor", 1'b1, 32'h0000F0F0, 32'h00000FF0, 3'd4, 1'b0, 5'd6, 1'b1, 1'b0);
    issue(32'h00000013, 32'h0, 32'h0, 32'h0);
    check_out("nop", 1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: A accepted, B waits three stalled cycles
    bus.out_ready = 1'b0;
    issue(32'h002082B3, 32'h0, 32'd7, 32'd8);
    check_out("bp_a", 1'b1, 32'd7, 32'd8, 3'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    bus.in_valid       = 1'b1;
    bus.in_instruction = 32'h123453B7;
    bus.rs1_data       = 32'h99;
    bus.rs2_data       = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall.in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check_out("bp_stall", 1'b1, 32'd7, 32'd8, 3'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    $display("[TB] issue instr=0x123453b7 accepted after stall");
    check_out("bp_b", 1'b1, 32'h0, 32'h12345000, 3'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    check("bp_done.out_valid", 32'(bus.out_valid), 32'd0);

    // Flush together with an accept while an entry is held
    bus.out_ready = 1'b0;
    issue(32'h002082B3, 32'h0, 32'd7, 32'd8);
    check("flush_hold.out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid       = 1'b1;
    bus.in_instruction = 32'h00000013;
    bus.flush          = 1'b1;
    bus.out_ready      = 1'b1;
    #1;
    check("flush.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    $display("[TB] flush with instr=0x00000013");
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush.out_valid", 32'(bus.out_valid), 32'd0);
    issue(32'h402081B3, 32'h0, 32'd10, 32'd3);
    check_out("post_flush", 1'b1, 32'd10, 32'd3, 3'd0, 1'b1, 5'd3, 1'b1, 1'b0);

    // Reset while stalled on a valid entry
    bus.out_ready = 1'b0;
    tick();
    check("stall.out_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    $display("[TB] reset during stall");
    check_out("rst_mid", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_release.in_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
